// File: rtl/riscv_multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle_ctrl_pkg
// Brief    : Shared datapath select encodings, FSM states and control word
//            for the RV32I multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_multicycle_ctrl_pkg;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } immediate_type_e;

    typedef enum logic [1:0] {
        PC_SRC_PC4    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JAL    = 2'd2,
        PC_SRC_JALR   = 2'd3
    } pc_src_e;

    typedef enum logic [2:0] {
        BRANCH_NONE = 3'd0,
        BRANCH_EQ   = 3'd1,
        BRANCH_NE   = 3'd2,
        BRANCH_LT   = 3'd3,
        BRANCH_GE   = 3'd4,
        BRANCH_LTU  = 3'd5,
        BRANCH_GEU  = 3'd6
    } branch_type_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } ctrl_state_e;

    typedef struct packed {
        alu_src_a_e      alu_src_a;
        alu_src_b_e      alu_src_b;
        alu_op_e         alu_op;
        immediate_type_e imm_type;
        branch_type_e    branch_type;
        logic [2:0]      funct3;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
    } ctrl_word_t;

    localparam ctrl_word_t C_CTRL_WORD_RESET = '{
        alu_src_a:   SRC_A_RS1,
        alu_src_b:   SRC_B_RS2,
        alu_op:      ALU_ADD,
        imm_type:    IMM_I,
        branch_type: BRANCH_NONE,
        funct3:      3'b000,
        is_load:     1'b0,
        is_store:    1'b0,
        is_branch:   1'b0,
        is_jal:      1'b0,
        is_jalr:     1'b0
    };

    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;

    localparam logic [2:0] C_F3_ADD = 3'b000;
    localparam logic [2:0] C_F3_SLL = 3'b001;
    localparam logic [2:0] C_F3_SRL = 3'b101;

    localparam logic [6:0] C_F7_BASE = 7'h00;
    localparam logic [6:0] C_F7_ALT  = 7'h20;

    // alt selects SUB/SRA in place of ADD/SRL; legality is checked by the caller
    function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_decoder.sv
`default_nettype none
// ============================================================================
// Module   : riscv_decoder
// Brief    : Combinational RV32I decoder producing the control word and an
//            illegal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_decoder
    import riscv_multicycle_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr,
    output ctrl_word_t      o_ctrl,
    output logic            o_illegal
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic       w_unused_fields;

    assign w_opcode        = i_instr[6:0];
    assign w_funct3        = i_instr[14:12];
    assign w_funct7        = i_instr[31:25];
    assign w_unused_fields = ^i_instr;

    always_comb begin
        o_ctrl    = C_CTRL_WORD_RESET;
        o_illegal = 1'b0;
        case (w_opcode)
            C_OPC_OP: begin
                if (w_funct7 == C_F7_BASE) begin
                    o_ctrl.alu_op = alu_op_from_funct3(w_funct3, 1'b0);
                end else if (w_funct7 == C_F7_ALT &&
                             (w_funct3 == C_F3_ADD || w_funct3 == C_F3_SRL)) begin
                    o_ctrl.alu_op = alu_op_from_funct3(w_funct3, 1'b1);
                end else begin
                    o_illegal = 1'b1;
                end
            end
            C_OPC_OP_IMM: begin
                o_ctrl.alu_src_b = SRC_B_IMM;
                // ADDI never becomes SUB: bit 30 there is immediate, not funct7
                if (w_funct3 == C_F3_SLL) begin
                    o_ctrl.alu_op = ALU_SLL;
                    o_illegal     = (w_funct7 != C_F7_BASE);
                end else if (w_funct3 == C_F3_SRL) begin
                    if (w_funct7 == C_F7_BASE) begin
                        o_ctrl.alu_op = ALU_SRL;
                    end else if (w_funct7 == C_F7_ALT) begin
                        o_ctrl.alu_op = ALU_SRA;
                    end else begin
                        o_illegal = 1'b1;
                    end
                end else begin
                    o_ctrl.alu_op = alu_op_from_funct3(w_funct3, 1'b0);
                end
            end
            C_OPC_LOAD: begin
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.is_load   = 1'b1;
                o_ctrl.funct3    = w_funct3;
                o_illegal        = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                   (w_funct3 == 3'b111);
            end
            C_OPC_STORE: begin
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.imm_type  = IMM_S;
                o_ctrl.is_store  = 1'b1;
                o_ctrl.funct3    = w_funct3;
                o_illegal        = (w_funct3 > 3'b010);
            end
            C_OPC_BRANCH: begin
                o_ctrl.alu_src_a = SRC_A_PC;
                o_ctrl.imm_type  = IMM_B;
                o_ctrl.is_branch = 1'b1;
                case (w_funct3)
                    3'b000:  o_ctrl.branch_type = BRANCH_EQ;
                    3'b001:  o_ctrl.branch_type = BRANCH_NE;
                    3'b100:  o_ctrl.branch_type = BRANCH_LT;
                    3'b101:  o_ctrl.branch_type = BRANCH_GE;
                    3'b110:  o_ctrl.branch_type = BRANCH_LTU;
                    3'b111:  o_ctrl.branch_type = BRANCH_GEU;
                    default: o_illegal = 1'b1;
                endcase
            end
            C_OPC_JAL: begin
                o_ctrl.alu_src_a = SRC_A_PC;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.imm_type  = IMM_J;
                o_ctrl.is_jal    = 1'b1;
            end
            C_OPC_JALR: begin
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.is_jalr   = 1'b1;
                o_illegal        = (w_funct3 != 3'b000);
            end
            C_OPC_LUI: begin
                o_ctrl.alu_src_a = SRC_A_ZERO;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.imm_type  = IMM_U;
                o_ctrl.alu_op    = ALU_LUI;
            end
            C_OPC_AUIPC: begin
                o_ctrl.alu_src_a = SRC_A_PC;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.imm_type  = IMM_U;
                o_ctrl.alu_op    = ALU_AUIPC;
            end
            default: o_illegal = 1'b1;
        endcase
        if (o_illegal) begin
            o_ctrl = C_CTRL_WORD_RESET;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle_ctrl
// Brief    : Multi-cycle RV32I control FSM with variable-latency memory
//            handshakes; outputs decode from state plus registered control word.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_multicycle_ctrl
    import riscv_multicycle_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            branch_taken_i,
    input  logic            imem_ready_i,
    input  logic            dmem_ready_i,
    output logic            imem_req_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [2:0]      dmem_funct3_o,
    output logic            ir_we_o,
    output logic            pc_we_o,
    output logic            reg_we_o,
    output logic [1:0]      alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [3:0]      alu_op_o,
    output logic [2:0]      imm_type_o,
    output logic [1:0]      pc_src_o,
    output logic [2:0]      branch_type_o,
    output logic [1:0]      wb_sel_o,
    output logic            retired_o,
    output logic            illegal_o,
    output logic            halted_o
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_next;
    ctrl_word_t  r_ctrl;
    ctrl_word_t  w_dec_ctrl;
    logic        w_dec_illegal;
    logic        r_illegal;

    logic        w_imem_req;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic        w_ir_we;
    logic        w_pc_we;
    logic        w_reg_we;
    logic        w_retired;
    pc_src_e     w_pc_src;
    wb_sel_e     w_wb_sel;

    riscv_decoder #(
        .XLEN (XLEN)
    ) u_decoder (
        .i_instr   (instr_i),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_FETCH;
            r_ctrl    <= C_CTRL_WORD_RESET;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_ctrl    <= w_dec_ctrl;
                r_illegal <= r_illegal | w_dec_illegal;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_reg_we     = 1'b0;
        w_retired    = 1'b0;
        w_pc_src     = PC_SRC_PC4;
        w_wb_sel     = WB_ALU;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready_i) begin
                    w_ir_we      = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_next = w_dec_illegal ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (r_ctrl.is_load || r_ctrl.is_store) begin
                    w_state_next = S_MEM;
                end else if (r_ctrl.is_branch) begin
                    w_pc_we      = 1'b1;
                    w_pc_src     = branch_taken_i ? PC_SRC_BRANCH : PC_SRC_PC4;
                    w_retired    = 1'b1;
                    w_state_next = S_FETCH;
                end else if (r_ctrl.is_jal || r_ctrl.is_jalr) begin
                    w_reg_we     = 1'b1;
                    w_wb_sel     = WB_PC4;
                    w_pc_we      = 1'b1;
                    w_pc_src     = r_ctrl.is_jal ? PC_SRC_JAL : PC_SRC_JALR;
                    w_retired    = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = r_ctrl.is_store;
                if (dmem_ready_i) begin
                    if (r_ctrl.is_load) begin
                        w_state_next = S_WB;
                    end else begin
                        w_pc_we      = 1'b1;
                        w_retired    = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_reg_we     = 1'b1;
                w_wb_sel     = r_ctrl.is_load ? WB_MEM : WB_ALU;
                w_pc_we      = 1'b1;
                w_retired    = 1'b1;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // Reset kills every strobe in the same cycle, even mid-access
        if (rst_i) begin
            w_imem_req = 1'b0;
            w_dmem_req = 1'b0;
            w_dmem_we  = 1'b0;
            w_ir_we    = 1'b0;
            w_pc_we    = 1'b0;
            w_reg_we   = 1'b0;
            w_retired  = 1'b0;
        end
    end

    assign imem_req_o    = w_imem_req;
    assign dmem_req_o    = w_dmem_req;
    assign dmem_we_o     = w_dmem_we;
    assign dmem_funct3_o = r_ctrl.funct3;
    assign ir_we_o       = w_ir_we;
    assign pc_we_o       = w_pc_we;
    assign reg_we_o      = w_reg_we;
    assign alu_src_a_o   = r_ctrl.alu_src_a;
    assign alu_src_b_o   = r_ctrl.alu_src_b;
    assign alu_op_o      = r_ctrl.alu_op;
    assign imm_type_o    = r_ctrl.imm_type;
    assign pc_src_o      = w_pc_src;
    assign branch_type_o = r_ctrl.branch_type;
    assign wb_sel_o      = w_wb_sel;
    assign retired_o     = w_retired;
    assign illegal_o     = r_illegal;
    assign halted_o      = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multicycle_ctrl
// Brief    : Scoreboard bench for the multi-cycle RV32I control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_ctrl;
    import riscv_multicycle_ctrl_pkg::*;

    localparam logic [31:0] C_ADD  = 32'h002081B3;
    localparam logic [31:0] C_LW   = 32'h0080A283;
    localparam logic [31:0] C_BEQ  = 32'h00000863;
    localparam logic [31:0] C_JAL  = 32'h100000EF;
    localparam logic [31:0] C_SW   = 32'h0020A423;
    localparam logic [31:0] C_SRAI = 32'h4030D093;
    localparam logic [31:0] C_LUI  = 32'h123452B7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        taken = 1'b0;
    logic        imem_rdy = 1'b0;
    logic        dmem_rdy = 1'b0;

    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retired, illegal, halted;
    logic [2:0] f3, imm, br;
    logic [1:0] src_a, src_b, pc_src, wb;
    logic [3:0] alu_op;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.XLEN(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_i        (instr),
        .branch_taken_i (taken),
        .imem_ready_i   (imem_rdy),
        .dmem_ready_i   (dmem_rdy),
        .imem_req_o     (imem_req),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_funct3_o  (f3),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .reg_we_o       (reg_we),
        .alu_src_a_o    (src_a),
        .alu_src_b_o    (src_b),
        .alu_op_o       (alu_op),
        .imm_type_o     (imm),
        .pc_src_o       (pc_src),
        .branch_type_o  (br),
        .wb_sel_o       (wb),
        .retired_o      (retired),
        .illegal_o      (illegal),
        .halted_o       (halted)
    );

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic       retired;
        logic       illegal;
        logic       halted;
        logic [2:0] f3;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic [2:0] imm;
        logic [2:0] br;
        logic [1:0] pc_src;
        logic [1:0] wb;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        imem_rdy;
        logic        dmem_rdy;
        logic        taken;
        logic [31:0] instr;
        obs_t        exp;
        obs_t        mask;
        string       tag;
    } ent_t;

    obs_t w_obs;
    assign w_obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retired, illegal, halted,
                    f3, src_a, src_b, alu_op, imm, br, pc_src, wb};

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t mk_mask(input bit en, input bit fl, input bit sel,
                                     input bit pc, input bit wbm, input bit f3m);
        obs_t m;
        m = '0;
        if (en) begin
            m.imem_req = 1'b1; m.dmem_req = 1'b1; m.dmem_we = 1'b1; m.ir_we = 1'b1;
            m.pc_we = 1'b1; m.reg_we = 1'b1; m.retired = 1'b1;
        end
        if (fl) begin
            m.illegal = 1'b1; m.halted = 1'b1;
        end
        if (sel) begin
            m.src_a = '1; m.src_b = '1; m.alu_op = '1; m.imm = '1; m.br = '1;
        end
        if (pc)  m.pc_src = '1;
        if (wbm) m.wb = '1;
        if (f3m) m.f3 = '1;
        return m;
    endfunction

    function automatic obs_t o_fetch(input logic rdy);
        obs_t o;
        o = '0;
        o.imem_req = 1'b1;
        o.ir_we    = rdy;
        return o;
    endfunction

    function automatic obs_t o_sel(input alu_src_a_e a, input alu_src_b_e b, input alu_op_e op,
                                   input immediate_type_e im, input branch_type_e bt);
        obs_t o;
        o = '0;
        o.src_a  = a;
        o.src_b  = b;
        o.alu_op = op;
        o.imm    = im;
        o.br     = bt;
        return o;
    endfunction

    task automatic push(input logic r, input logic ir, input logic dr, input logic tk,
                        input logic [31:0] ins, input obs_t e, input obs_t m, input string tag);
        ent_t x;
        x.rst = r; x.imem_rdy = ir; x.dmem_rdy = dr; x.taken = tk;
        x.instr = ins; x.exp = e; x.mask = m; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        ent_t e;
        push(1, 1, 1, 1, C_ADD, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst_strobes");
        push(1, 1, 1, 1, C_ADD, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst_strobes2");
        push(0, 0, 1, 0, C_ADD, o_fetch(0), mk_mask(1, 1, 1, 1, 1, 1), "rst_fetch_idle");
        push(0, 0, 1, 0, C_ADD, o_fetch(0), mk_mask(1, 1, 1, 1, 1, 1), "rst_fetch_wait");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL reset/%s: got %h expected %h", e.tag, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_add();
        ent_t e;
        obs_t x;
        push(1, 0, 0, 0, C_ADD, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst");
        push(0, 1, 1, 0, C_ADD, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "fetch");
        push(0, 1, 1, 0, C_ADD, '0, mk_mask(1, 1, 0, 0, 0, 0), "decode");
        x = o_sel(SRC_A_RS1, SRC_B_RS2, ALU_ADD, IMM_I, BRANCH_NONE);
        push(0, 1, 1, 0, C_ADD, x, mk_mask(1, 1, 1, 0, 0, 0), "exec");
        x.reg_we = 1'b1; x.pc_we = 1'b1; x.retired = 1'b1; x.pc_src = PC_SRC_PC4; x.wb = WB_ALU;
        push(0, 1, 1, 0, C_ADD, x, mk_mask(1, 1, 1, 1, 1, 0), "wb");
        push(0, 0, 1, 0, C_ADD, o_fetch(0), mk_mask(1, 1, 0, 0, 0, 0), "next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL add/%s: got %h expected %h", e.tag, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_load_wait();
        ent_t e;
        obs_t x;
        push(1, 0, 0, 0, C_LW, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst");
        push(0, 1, 0, 0, C_LW, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "fetch");
        push(0, 1, 0, 0, C_LW, '0, mk_mask(1, 1, 0, 0, 0, 0), "decode");
        x = o_sel(SRC_A_RS1, SRC_B_IMM, ALU_ADD, IMM_I, BRANCH_NONE);
        push(0, 1, 0, 0, C_LW, x, mk_mask(1, 1, 1, 0, 0, 0), "exec");
        x.dmem_req = 1'b1; x.f3 = 3'b010;
        for (int i = 0; i < 3; i++)
            push(0, 1, 0, 0, C_LW, x, mk_mask(1, 1, 1, 0, 0, 1), "mem_wait");
        push(0, 1, 1, 0, C_LW, x, mk_mask(1, 1, 1, 0, 0, 1), "mem_ready");
        x = o_sel(SRC_A_RS1, SRC_B_IMM, ALU_ADD, IMM_I, BRANCH_NONE);
        x.reg_we = 1'b1; x.pc_we = 1'b1; x.retired = 1'b1; x.pc_src = PC_SRC_PC4; x.wb = WB_MEM;
        push(0, 1, 1, 0, C_LW, x, mk_mask(1, 1, 1, 1, 1, 0), "wb");
        push(0, 0, 0, 0, C_LW, o_fetch(0), mk_mask(1, 1, 0, 0, 0, 0), "next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL load/%s: got %h expected %h", e.tag, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_branch();
        ent_t e;
        obs_t x;
        push(1, 0, 0, 0, C_BEQ, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst");
        push(0, 1, 0, 1, C_BEQ, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "fetch_t");
        push(0, 1, 0, 1, C_BEQ, '0, mk_mask(1, 1, 0, 0, 0, 0), "decode_t");
        x = o_sel(SRC_A_PC, SRC_B_RS2, ALU_ADD, IMM_B, BRANCH_EQ);
        x.pc_we = 1'b1; x.retired = 1'b1; x.pc_src = PC_SRC_BRANCH;
        push(0, 1, 0, 1, C_BEQ, x, mk_mask(1, 1, 1, 1, 0, 0), "exec_taken");
        push(0, 1, 0, 1, C_BEQ, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "fetch_nt");
        push(0, 1, 0, 1, C_BEQ, '0, mk_mask(1, 1, 0, 0, 0, 0), "decode_nt");
        x.pc_src = PC_SRC_PC4;
        push(0, 1, 0, 0, C_BEQ, x, mk_mask(1, 1, 1, 1, 0, 0), "exec_not_taken");
        push(0, 0, 0, 0, C_BEQ, o_fetch(0), mk_mask(1, 1, 0, 0, 0, 0), "next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL branch/%s: got %h expected %h", e.tag, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_jal();
        ent_t e;
        obs_t x;
        push(1, 0, 0, 0, C_JAL, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst");
        push(0, 1, 0, 0, C_JAL, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "fetch");
        push(0, 1, 0, 0, C_JAL, '0, mk_mask(1, 1, 0, 0, 0, 0), "decode");
        x = o_sel(SRC_A_PC, SRC_B_IMM, ALU_ADD, IMM_J, BRANCH_NONE);
        x.reg_we = 1'b1; x.pc_we = 1'b1; x.retired = 1'b1; x.pc_src = PC_SRC_JAL; x.wb = WB_PC4;
        push(0, 1, 0, 0, C_JAL, x, mk_mask(1, 1, 1, 1, 1, 0), "exec");
        push(0, 0, 0, 0, C_JAL, o_fetch(0), mk_mask(1, 1, 0, 0, 0, 0), "next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL jal/%s: got %h expected %h", e.tag, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_illegal();
        ent_t e;
        obs_t x;
        logic [31:0] bad [4];
        bad[0] = 32'h402091B3;  // R-type funct7=0x20 with SLL
        bad[1] = 32'h0080B283;  // load funct3=011
        bad[2] = 32'h00009067;  // JALR funct3=001
        bad[3] = 32'h00000073;  // SYSTEM opcode
        x = '0; x.illegal = 1'b1; x.halted = 1'b1;
        push(1, 0, 0, 0, 32'h0, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst");
        push(0, 1, 1, 1, 32'h0, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "fetch");
        push(0, 1, 1, 1, 32'h0, '0, mk_mask(1, 1, 0, 0, 0, 0), "decode");
        for (int i = 0; i < 10; i++)
            push(0, 1, 1, 1, 32'h0, x, mk_mask(1, 1, 0, 0, 0, 0), "halted");
        push(1, 1, 1, 1, 32'h0, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst_exit");
        push(0, 0, 0, 0, 32'h0, o_fetch(0), mk_mask(1, 1, 0, 0, 0, 0), "fetch_cleared");
        for (int i = 0; i < 4; i++) begin
            push(1, 0, 0, 0, bad[i], '0, mk_mask(1, 0, 0, 0, 0, 0), "v_rst");
            push(0, 1, 0, 0, bad[i], o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "v_fetch");
            push(0, 1, 0, 0, bad[i], '0, mk_mask(1, 1, 0, 0, 0, 0), "v_decode");
            push(0, 1, 1, 1, bad[i], x, mk_mask(1, 1, 0, 0, 0, 0), "v_halted");
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL illegal/%s instr %h: got %h expected %h", e.tag, e.instr,
                         w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_store_reset();
        ent_t e;
        obs_t x;
        push(1, 0, 0, 0, C_SW, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst");
        push(0, 1, 0, 0, C_SW, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "fetch");
        push(0, 1, 0, 0, C_SW, '0, mk_mask(1, 1, 0, 0, 0, 0), "decode");
        x = o_sel(SRC_A_RS1, SRC_B_IMM, ALU_ADD, IMM_S, BRANCH_NONE);
        push(0, 1, 0, 0, C_SW, x, mk_mask(1, 1, 1, 0, 0, 0), "exec");
        x.dmem_req = 1'b1; x.dmem_we = 1'b1; x.f3 = 3'b010;
        push(0, 1, 0, 0, C_SW, x, mk_mask(1, 1, 1, 0, 0, 1), "mem_wait");
        push(1, 1, 0, 0, C_SW, '0, mk_mask(1, 0, 0, 0, 0, 0), "mem_reset");
        push(0, 0, 0, 0, C_SW, o_fetch(0), mk_mask(1, 1, 0, 0, 0, 0), "fetch_after");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL store_reset/%s: got %h expected %h", e.tag, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        obs_t x;
        push(1, 0, 0, 0, C_SW, '0, mk_mask(1, 0, 0, 0, 0, 0), "rst");
        push(0, 1, 1, 0, C_SW, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "sw_fetch");
        push(0, 1, 1, 0, C_SW, '0, mk_mask(1, 1, 0, 0, 0, 0), "sw_decode");
        x = o_sel(SRC_A_RS1, SRC_B_IMM, ALU_ADD, IMM_S, BRANCH_NONE);
        push(0, 1, 1, 0, C_SW, x, mk_mask(1, 1, 1, 0, 0, 0), "sw_exec");
        x.dmem_req = 1'b1; x.dmem_we = 1'b1; x.f3 = 3'b010;
        x.pc_we = 1'b1; x.retired = 1'b1; x.pc_src = PC_SRC_PC4;
        push(0, 1, 1, 0, C_SW, x, mk_mask(1, 1, 1, 1, 0, 1), "sw_mem");
        push(0, 1, 1, 0, C_SRAI, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "srai_fetch");
        push(0, 1, 1, 0, C_SRAI, '0, mk_mask(1, 1, 0, 0, 0, 0), "srai_decode");
        x = o_sel(SRC_A_RS1, SRC_B_IMM, ALU_SRA, IMM_I, BRANCH_NONE);
        push(0, 1, 1, 0, C_SRAI, x, mk_mask(1, 1, 1, 0, 0, 0), "srai_exec");
        x.reg_we = 1'b1; x.pc_we = 1'b1; x.retired = 1'b1; x.pc_src = PC_SRC_PC4; x.wb = WB_ALU;
        push(0, 1, 1, 0, C_SRAI, x, mk_mask(1, 1, 1, 1, 1, 0), "srai_wb");
        push(0, 1, 1, 0, C_LUI, o_fetch(1), mk_mask(1, 1, 0, 0, 0, 0), "lui_fetch");
        push(0, 1, 1, 0, C_LUI, '0, mk_mask(1, 1, 0, 0, 0, 0), "lui_decode");
        x = o_sel(SRC_A_ZERO, SRC_B_IMM, ALU_LUI, IMM_U, BRANCH_NONE);
        push(0, 1, 1, 0, C_LUI, x, mk_mask(1, 1, 1, 0, 0, 0), "lui_exec");
        x.reg_we = 1'b1; x.pc_we = 1'b1; x.retired = 1'b1; x.pc_src = PC_SRC_PC4; x.wb = WB_ALU;
        push(0, 1, 1, 0, C_LUI, x, mk_mask(1, 1, 1, 1, 1, 0), "lui_wb");
        push(0, 0, 0, 0, C_LUI, o_fetch(0), mk_mask(1, 1, 0, 0, 0, 0), "next_fetch");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            rst = e.rst; imem_rdy = e.imem_rdy; dmem_rdy = e.dmem_rdy; taken = e.taken; instr = e.instr;
            #3;
            checks++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL b2b/%s: got %h expected %h", e.tag, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_store_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control FSM that sequences the RV32I datapath (ALU, register file, immediate extender, PC and instruction/data memory ports) over several clock cycles per instruction, replacing the single-cycle combinational decoder. It issues the shared datapath selects (`alu_src_a_e`, `alu_src_b_e`, `alu_op_e`, `immediate_type_e`, `pc_src_e`) once per step. It also handles handshakes with instruction and data memories that have variable latency.

## Interface
- `XLEN`, default 32: instruction width.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `instr_i`  in  XLEN  instruction register contents; the datapath loads it on `ir_we_o`.
- `branch_taken_i`  in  1  comparator result for the current `branch_type_o`.
- `imem_ready_i` / `dmem_ready_i`  in  1  memory completes the access this cycle.
- `imem_req_o`  out  1  instruction fetch request.
- `dmem_req_o`, `dmem_we_o`  out  1  data access request and write enable.
- `dmem_funct3_o`  out  3  access size/sign (LB…SW encoding).
- `ir_we_o`, `pc_we_o`, `reg_we_o`  out  1  register enables.
- `alu_src_a_o`  out  2  `alu_src_a_e`.
- `alu_src_b_o`  out  2  `alu_src_b_e`.
- `alu_op_o`  out  4  `alu_op_e`.
- `imm_type_o`  out  3  `immediate_type_e`.
- `pc_src_o`  out  2  `pc_src_e`.
- `branch_type_o`  out  3  `branch_type_e`.
- `wb_sel_o`  out  2  `wb_sel_e`.
- `retired_o`  out  1  one-cycle pulse when an instruction completes.
- `illegal_o`, `halted_o`  out  1  sticky illegal-instruction flag and halt status.

## Operation
- States: `S_FETCH`, `S_DECODE`, `S_EXEC`, `S_MEM`, `S_WB`, `S_HALT`.
- **S_FETCH:** `imem_req_o`=1 until `imem_ready_i`. On ready: `ir_we_o`=1, then go to `S_DECODE`.
- **S_DECODE:** decode `instr_i` into a registered control word.
  - Illegal instruction → `S_HALT`, set `illegal_o`.
  - Otherwise → `S_EXEC`.
- **S_EXEC:**
  - R/I-type, LUI, AUIPC → `S_WB`.
  - LOAD/STORE: ALU computes rs1+imm → `S_MEM`.
  - BRANCH: `pc_we_o`=1, `pc_src_o` = `BRANCH` if `branch_taken_i`, else `PC4`; `retired_o`=1 → `S_FETCH`.
  - JAL/JALR: `reg_we_o`=1, `wb_sel_o`=`WB_PC4`, `pc_we_o`=1, `pc_src_o` = `JAL`/`JALR`; `retired_o` → `S_FETCH`.
- **S_MEM:** `dmem_req_o`=1. `dmem_we_o`=1 for stores. Both, plus `dmem_funct3_o`, are held stable until `dmem_ready_i`.
  - Load → `S_WB`.
  - Store → `pc_we_o`(PC4), `retired_o` → `S_FETCH`.
- **S_WB:** `reg_we_o`=1; `wb_sel_o` = `WB_MEM` for loads, else `WB_ALU`; `pc_we_o`(PC4), `retired_o` → `S_FETCH`.
- **S_HALT:** all enables 0; exits only via reset.
- Illegal instructions:
  - Unknown opcode.
  - R-type funct7 ∉ {0x00, 0x20}, or funct7=0x20 with funct3 ∉ {ADD, SRL}.
  - SLLI funct7≠0; SRLI/SRAI funct7 ∉ {0x00, 0x20}.
  - Load funct3 ∈ {011, 110, 111}; store funct3 > 010.
  - Branch funct3 ∈ {010, 011}; JALR funct3≠0.
- ALU mapping:
  - SUB only for R-type funct7=0x20; SRA for funct7=0x20 with funct3=101.
  - LUI → `ALU_LUI`; AUIPC → `ALU_AUIPC` with src A=PC.
  - LOAD/STORE/JAL/JALR/BRANCH use `ALU_ADD` for address/target.
- Source A: PC for AUIPC/JAL/BRANCH, ZERO for LUI, else RS1.
- Source B: IMM for everything except R-type and BRANCH.

## Timing
- Reset: state=`S_FETCH`, control word cleared, `illegal_o`=0.
  - All enables/requests 0; selects 0 (`RS1`, `RS2`, `ALU_ADD`, `IMM_I`, `PC4`, `BRANCH_NONE`, `WB_ALU`).
- While `rst_i`=1, every enable and request output is forced to 0 combinationally, even mid-`S_MEM`.
- Outputs are decoded from the state register plus the registered control word. Only `pc_src_o` in EXEC depends combinationally on `branch_taken_i`, and ready-qualified enables depend on the ready inputs.
- Latency with zero-wait memory:
  - Branch/JAL/JALR: 3 cycles.
  - ALU ops, LUI, AUIPC, store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds one cycle.
- Ready asserted without a request is ignored.
- `retired_o` coincides with the final `pc_we_o`.

## Structure
- Add to the shared package:
  - `wb_sel_e` (`WB_ALU`=0, `WB_MEM`, `WB_PC4`).
  - `ctrl_state_e`.
  - packed struct `ctrl_word_t` bundling all selects, `is_load`, `is_store`.
- Sub-module `riscv_decoder`: combinational, `instr` → `ctrl_word_t` + `illegal`.

## Test plan
- `add x3,x1,x2` (0x002081B3), readies tied 1 → FETCH, DECODE, EXEC, WB.
  - `ALU_ADD` with RS1/RS2; `reg_we_o` only in WB; `retired_o` on cycle 4.
- `lw x5,8(x1)` (0x0080A283), `dmem_ready_i` low 3 cycles → `dmem_req_o` high for 4 cycles with funct3=010.
  - `wb_sel_o`=`WB_MEM`; 8 cycles total.
- `beq x0,x0,16` (0x00000863):
  - taken → `pc_src_o`=`BRANCH`, `BRANCH_EQ`, `IMM_B`, retired in 3 cycles, no `reg_we_o`.
  - repeat not-taken → `PC4`.
- `jal x1,256` (0x100000EF) → EXEC asserts `reg_we_o`, `WB_PC4`, `pc_src_o`=`JAL`, `IMM_J`, src A=PC.
- Illegal instruction 0x00000000 → `illegal_o`/`halted_o` set after DECODE, no enables for 10 cycles; `rst_i` returns the FSM to FETCH with flags cleared.
- `sw x2,8(x1)` (0x0020A423), `rst_i` asserted in `S_MEM` while `dmem_ready_i`=0 → `dmem_req_o`/`dmem_we_o` go 0 that cycle, FETCH on the next cycle, no `retired_o`.
